cart_bank_ctrl: RTL and testbench
=================================

CART_BANK_CTRL -- requirements
Module: cart_bank_ctrl

Interface
REQ-001 Parameter ROM_ADDR_BITS, default 15; meaning: width of the ROM byte address, 32 KB maximum cartridge.
REQ-002 clk_i  input  1  system clock; all state is clocked on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 enable_i  input  1  CPU-cycle strobe, high for one clk_i cycle per CPU cycle.
REQ-005 load_i  input  1  loader active; while high, bank state is held at its defaults.
REQ-006 mode_i  input  3  scheme: 0 none, 1 F8, 2 F6, 3 F4, 4 E0, 5 3F, 6-7 treated as 0.
REQ-007 adr_i  input  13  CPU address bits 12:0.
REQ-008 we_i  input  1  CPU write.
REQ-009 dat_i  input  8  CPU write data.
REQ-010 rom_adr_o  output  ROM_ADDR_BITS  ROM byte address; combinational from adr_i and registered bank state.
REQ-011 bank_o  output  3  current bank for F8/F6/F4, lower-2K bank for 3F, slice-0 bank for E0.
REQ-012 hotspot_o  output  1  registered one-cycle pulse when a bank-register update is accepted.

Function
REQ-013 An access is qualified only when enable_i=1 and load_i=0; state changes only on qualified accesses.
REQ-014 Mode 0: rom_adr_o = adr_i[11:0], zero-extended.
REQ-015 F8 hotspots: 1FF8-1FF9, read or write; bank = adr_i[0]; rom_adr_o = {bank[0], adr_i[11:0]}.
REQ-016 F6 hotspots: 1FF6-1FF9; bank = adr_i[3:0]-6; rom_adr_o = {bank[1:0], adr_i[11:0]}.
REQ-017 F4 hotspots: 1FF4-1FFB; bank = adr_i[3:0]-4; rom_adr_o = {bank[2:0], adr_i[11:0]}.
REQ-018 Hotspots in modes 1-3 decode only when adr_i[12]=1; the hotspot read still returns ROM data at the old bank, and the new bank applies from the next clk_i cycle.
REQ-019 E0 maps four 1 KB slices, s = adr_i[11:10]; rom_adr_o = {sel[s], adr_i[9:0]}, with sel[3] fixed at 7.
REQ-020 E0 hotspots (adr_i[12]=1): 1FE0-1FE7 set sel[0], 1FE8-1FEF set sel[1], 1FF0-1FF7 set sel[2]; value = adr_i[2:0].
REQ-021 3F: a qualified write with adr_i[12]=0 and adr_i[7:6]=00 sets bank = dat_i[2:0], and hotspot_o pulses.
REQ-022 3F reads never switch banks.
REQ-023 3F mapping: adr_i[11]=0 gives {bank, adr_i[10:0]}; adr_i[11]=1 gives {3'b111, adr_i[10:0]}.
REQ-024 Defaults: F8 bank 1, F6 bank 3, F4 bank 7, 3F bank 0, E0 sel[0..2] = 4, 5, 6.
REQ-025 mode_i is registered; when mode_i differs from the registered mode, all bank state loads the new mode's defaults on the next clk_i edge.
REQ-026 During a mode change, hotspot accesses in that same cycle are ignored.
REQ-027 load_i high forces defaults every cycle for the current mode; normal operation resumes the cycle after load_i falls.
REQ-028 rom_adr_o is truncated to ROM_ADDR_BITS, so higher bank bits wrap.
REQ-029 Repeated qualified accesses to the same hotspot are idempotent; only one hotspot_o pulse occurs per qualified access.
REQ-030 Addresses with adr_i[12]=0 never change state except for 3F writes.
REQ-031 In modes 0 and 3F, 1FF4-1FFB has no effect.

Reset
REQ-032 While rst_ni=0: registered mode = 0, all bank state = 0, hotspot_o = 0, bank_o = 0.
REQ-033 After reset is released, the first clk_i edge loads the defaults for the current mode_i, through the mode-change rule.
REQ-034 Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Verification
REQ-035 mode_i=1, read 1FF8 with enable_i -> bank_o 0 next cycle, hotspot_o pulse; read 1ABC -> rom_adr_o = 0x0ABC.
REQ-036 mode_i=3, read 1FFB -> bank_o 7; read 1FF4 with enable_i=0 -> bank_o stays 7; with enable_i=1 -> 0.
REQ-037 mode_i=4, read 1FE9 then 1FF3 -> rom_adr_o for 1400 = 0x0400, for 1800 = 0x0C00, for 1C00 = 0x1C00.
REQ-038 mode_i=5, write 0x03 to 0x003F -> 1000 maps to 0x1800, 1800 maps to 0x3800; read 0x003F -> no change.
REQ-039 mode_i changes 2->1 with the F6 bank at 0 -> bank_o = 1 next cycle; load_i=1 during a hotspot access -> no pulse, bank_o = default.
REQ-040 rst_ni pulsed low between clock edges -> outputs 0 immediately; after release -> mode defaults appear on the first edge.

Source files
------------

// File: rtl/cart_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cart_bank_ctrl
//  Purpose  : Cartridge ROM bank-switching controller. Decodes CPU accesses
//             to bank-select hotspots for the F8, F6, F4, E0 and 3F schemes,
//             holds the bank state, and forms the ROM byte address from the
//             CPU address and the current bank(s).
//
//  Ports    : clk_i      - system clock, rising-edge active
//             rst_ni     - asynchronous active-low reset
//             enable_i   - one-cycle strobe per CPU cycle
//             load_i     - loader active; bank state held at defaults
//             mode_i     - banking scheme (0 none, 1 F8, 2 F6, 3 F4,
//                          4 E0, 5 3F, 6-7 behave as 0)
//             adr_i      - CPU address bits 12:0
//             we_i       - CPU write
//             dat_i      - CPU write data
//             rom_adr_o  - ROM byte address (combinational)
//             bank_o     - current bank / lower-2K bank / slice-0 bank
//             hotspot_o  - one-cycle pulse after an accepted bank update
//
//  Revision : 1.0 - initial release
// ============================================================================
module cart_bank_ctrl #(
   parameter int ROM_ADDR_BITS = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enable_i,
   input  logic                     load_i,
   input  logic [2:0]               mode_i,
   input  logic [12:0]              adr_i,
   input  logic                     we_i,
   input  logic [7:0]               dat_i,
   output logic [ROM_ADDR_BITS-1:0] rom_adr_o,
   output logic [2:0]               bank_o,
   output logic                     hotspot_o
);

   // Scheme encodings
   localparam logic [2:0] c_MODE_NONE = 3'd0;
   localparam logic [2:0] c_MODE_F8   = 3'd1;
   localparam logic [2:0] c_MODE_F6   = 3'd2;
   localparam logic [2:0] c_MODE_F4   = 3'd3;
   localparam logic [2:0] c_MODE_E0   = 3'd4;
   localparam logic [2:0] c_MODE_3F   = 3'd5;

   // E0 slice defaults; slice 3 is hard-wired to the last 1 KB.
   localparam logic [2:0] c_E0_SEL0_DEF = 3'd4;
   localparam logic [2:0] c_E0_SEL1_DEF = 3'd5;
   localparam logic [2:0] c_E0_SEL2_DEF = 3'd6;
   localparam logic [2:0] c_E0_SEL3     = 3'd7;

   // Widest address any scheme produces (F4: 3 bank bits + 12 offset bits).
   localparam int c_FULL_BITS = 15;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   logic [2:0] r_mode;
   logic [2:0] r_bank;      // F8/F6/F4 bank, 3F lower-2K bank
   logic [2:0] r_sel0;      // E0 slice selects
   logic [2:0] r_sel1;
   logic [2:0] r_sel2;
   logic       r_hotspot;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic [2:0]             w_mode;       // mode_i with reserved codes folded to 0
   logic                   w_mode_chg;
   logic [11:0]            w_lo;         // address within the 4 KB window
   logic                   w_bank_we;    // access targets r_bank
   logic [2:0]             w_bank_nxt;
   logic [2:0]             w_sel_we;     // one-hot E0 slice update
   logic                   w_hit;
   logic [2:0]             w_e0_sel;     // select for the addressed E0 slice
   logic [c_FULL_BITS-1:0] w_rom_full;
   logic                   w_unused;

   assign w_mode     = (mode_i > c_MODE_3F) ? c_MODE_NONE : mode_i;
   assign w_mode_chg = (w_mode != r_mode);
   assign w_lo       = adr_i[11:0];
   assign w_hit      = w_bank_we | (|w_sel_we);

   // Only the low three data bits select a 3F bank.
   assign w_unused   = ^dat_i[7:3];

   function automatic logic [2:0] f_default_bank(input logic [2:0] mode);
      case (mode)
         c_MODE_F8: f_default_bank = 3'd1;
         c_MODE_F6: f_default_bank = 3'd3;
         c_MODE_F4: f_default_bank = 3'd7;
         default:   f_default_bank = 3'd0;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Hotspot decode (against the registered mode). Bank offsets are taken
   // modulo the bank count, which makes "adr - base" a plain narrow subtract:
   // F6 6..9 -> (adr[1:0]-2) mod 4, F4 4..B -> (adr[2:0]-4) mod 8.
   // ------------------------------------------------------------------------
   always_comb begin
      w_bank_we  = 1'b0;
      w_bank_nxt = r_bank;
      w_sel_we   = 3'b000;
      case (r_mode)
         c_MODE_F8: begin
            if (adr_i[12] && (w_lo >= 12'hFF8) && (w_lo <= 12'hFF9)) begin
               w_bank_we  = 1'b1;
               w_bank_nxt = {2'b00, adr_i[0]};
            end
         end
         c_MODE_F6: begin
            if (adr_i[12] && (w_lo >= 12'hFF6) && (w_lo <= 12'hFF9)) begin
               w_bank_we  = 1'b1;
               w_bank_nxt = {1'b0, adr_i[1:0] - 2'd2};
            end
         end
         c_MODE_F4: begin
            if (adr_i[12] && (w_lo >= 12'hFF4) && (w_lo <= 12'hFFB)) begin
               w_bank_we  = 1'b1;
               w_bank_nxt = adr_i[2:0] - 3'd4;
            end
         end
         c_MODE_E0: begin
            if (adr_i[12] && (w_lo >= 12'hFE0) && (w_lo <= 12'hFF7)) begin
               case (adr_i[4:3])
                  2'b00:   w_sel_we = 3'b001;
                  2'b01:   w_sel_we = 3'b010;
                  default: w_sel_we = 3'b100;
               endcase
            end
         end
         c_MODE_3F: begin
            // Writes anywhere in the low 4 KB with adr[7:6]=00 select the bank.
            if (we_i && !adr_i[12] && (adr_i[7:6] == 2'b00)) begin
               w_bank_we  = 1'b1;
               w_bank_nxt = dat_i[2:0];
            end
         end
         default: begin
            w_bank_we = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bank state. A mode change wins over everything and loads the new mode's
   // defaults; load_i holds the current mode's defaults; otherwise a
   // qualified hotspot access updates the state and pulses hotspot_o.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mode    <= c_MODE_NONE;
         r_bank    <= 3'd0;
         r_sel0    <= 3'd0;
         r_sel1    <= 3'd0;
         r_sel2    <= 3'd0;
         r_hotspot <= 1'b0;
      end else begin
         r_hotspot <= 1'b0;
         if (w_mode_chg) begin
            r_mode <= w_mode;
            r_bank <= f_default_bank(w_mode);
            r_sel0 <= c_E0_SEL0_DEF;
            r_sel1 <= c_E0_SEL1_DEF;
            r_sel2 <= c_E0_SEL2_DEF;
         end else if (load_i) begin
            r_bank <= f_default_bank(r_mode);
            r_sel0 <= c_E0_SEL0_DEF;
            r_sel1 <= c_E0_SEL1_DEF;
            r_sel2 <= c_E0_SEL2_DEF;
         end else if (enable_i && w_hit) begin
            r_hotspot <= 1'b1;
            if (w_bank_we) begin
               r_bank <= w_bank_nxt;
            end
            if (w_sel_we[0]) begin
               r_sel0 <= adr_i[2:0];
            end
            if (w_sel_we[1]) begin
               r_sel1 <= adr_i[2:0];
            end
            if (w_sel_we[2]) begin
               r_sel2 <= adr_i[2:0];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // ROM address formation
   // ------------------------------------------------------------------------
   always_comb begin
      case (adr_i[11:10])
         2'b00:   w_e0_sel = r_sel0;
         2'b01:   w_e0_sel = r_sel1;
         2'b10:   w_e0_sel = r_sel2;
         default: w_e0_sel = c_E0_SEL3;
      endcase
   end

   always_comb begin
      case (r_mode)
         c_MODE_F8: w_rom_full = {2'b00, r_bank[0], w_lo};
         c_MODE_F6: w_rom_full = {1'b0, r_bank[1:0], w_lo};
         c_MODE_F4: w_rom_full = {r_bank, w_lo};
         c_MODE_E0: w_rom_full = {2'b00, w_e0_sel, adr_i[9:0]};
         c_MODE_3F: begin
            // Upper 2 KB is always the last bank.
            if (adr_i[11]) begin
               w_rom_full = {1'b0, 3'b111, adr_i[10:0]};
            end else begin
               w_rom_full = {1'b0, r_bank, adr_i[10:0]};
            end
         end
         default:   w_rom_full = {3'b000, w_lo};
      endcase
   end

   // Narrow ROMs drop the high bank bits, so banks wrap.
   generate
      if (ROM_ADDR_BITS <= c_FULL_BITS) begin : g_rom_trunc
         assign rom_adr_o = w_rom_full[ROM_ADDR_BITS-1:0];
      end else begin : g_rom_ext
         assign rom_adr_o = {{(ROM_ADDR_BITS-c_FULL_BITS){1'b0}}, w_rom_full};
      end
   endgenerate

   assign bank_o    = (r_mode == c_MODE_E0) ? r_sel0 : r_bank;
   assign hotspot_o = r_hotspot;

endmodule
`default_nettype wire

// File: tb/tb_cart_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cart_bank_ctrl
//  Purpose  : Directed self-checking bench for cart_bank_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cart_bank_ctrl;

   logic        clk_i;
   logic        rst_ni;
   logic        enable_i;
   logic        load_i;
   logic [2:0]  mode_i;
   logic [12:0] adr_i;
   logic        we_i;
   logic [7:0]  dat_i;
   logic [14:0] rom_adr_o;
   logic [2:0]  bank_o;
   logic        hotspot_o;

   int n_checks = 0;
   int n_errors = 0;

   cart_bank_ctrl #(.ROM_ADDR_BITS(15)) u_dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .enable_i  (enable_i),
      .load_i    (load_i),
      .mode_i    (mode_i),
      .adr_i     (adr_i),
      .we_i      (we_i),
      .dat_i     (dat_i),
      .rom_adr_o (rom_adr_o),
      .bank_o    (bank_o),
      .hotspot_o (hotspot_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // One CPU cycle presented on the next edge; address is left in place.
   task automatic access(input logic [12:0] a, input logic we, input logic [7:0] d,
                         input logic en);
      adr_i    = a;
      we_i     = we;
      dat_i    = d;
      enable_i = en;
      step();
      enable_i = 1'b0;
      we_i     = 1'b0;
   endtask

   task automatic rom_at(input string tag, input logic [12:0] a, input logic [14:0] exp);
      adr_i = a;
      #1;
      check(tag, {17'd0, rom_adr_o}, {17'd0, exp});
   endtask

   initial begin
      rst_ni   = 1'b1;
      enable_i = 1'b0;
      load_i   = 1'b0;
      mode_i   = 3'd1;
      adr_i    = 13'h0000;
      we_i     = 1'b0;
      dat_i    = 8'h00;
      #1 rst_ni = 1'b0;
      #7;
      // ---- reset state ----
      check("rst_bank",    {29'd0, bank_o}, 32'd0);
      check("rst_hotspot", {31'd0, hotspot_o}, 32'd0);
      check("rst_rom",     {17'd0, rom_adr_o}, 32'd0);
      #4 rst_ni = 1'b1;            // released between edges
      step();
      check("f8_default", {29'd0, bank_o}, 32'd1);
      check("f8_no_pulse", {31'd0, hotspot_o}, 32'd0);

      // ---- F8 ----
      adr_i = 13'h1FF8; enable_i = 1'b1; #1;
      check("f8_old_bank_read", {17'd0, rom_adr_o}, 32'h1FF8);
      step(); enable_i = 1'b0;
      check("f8_new_bank_rom", {17'd0, rom_adr_o}, 32'h0FF8);
      check("f8_bank0", {29'd0, bank_o}, 32'd0);
      check("f8_pulse", {31'd0, hotspot_o}, 32'd1);
      step();
      check("f8_pulse_end", {31'd0, hotspot_o}, 32'd0);
      rom_at("f8_rom_1abc", 13'h1ABC, 15'h0ABC);
      access(13'h1FF9, 1'b0, 8'h00, 1'b1);
      check("f8_bank1", {29'd0, bank_o}, 32'd1);
      access(13'h1FF9, 1'b0, 8'h00, 1'b1);
      check("f8_repeat_bank", {29'd0, bank_o}, 32'd1);
      check("f8_repeat_pulse", {31'd0, hotspot_o}, 32'd1);
      rom_at("f8_rom_bank1", 13'h1ABC, 15'h1ABC);
      access(13'h0FF8, 1'b0, 8'h00, 1'b1);
      check("f8_a12_low_bank", {29'd0, bank_o}, 32'd1);
      check("f8_a12_low_pulse", {31'd0, hotspot_o}, 32'd0);

      // ---- F4 ----
      mode_i = 3'd3; step();
      check("f4_default", {29'd0, bank_o}, 32'd7);
      access(13'h1FFB, 1'b0, 8'h00, 1'b1);
      check("f4_1ffb", {29'd0, bank_o}, 32'd7);
      check("f4_1ffb_pulse", {31'd0, hotspot_o}, 32'd1);
      access(13'h1FF4, 1'b0, 8'h00, 1'b0);
      check("f4_noen", {29'd0, bank_o}, 32'd7);
      check("f4_noen_pulse", {31'd0, hotspot_o}, 32'd0);
      access(13'h1FF4, 1'b0, 8'h00, 1'b1);
      check("f4_1ff4", {29'd0, bank_o}, 32'd0);
      rom_at("f4_rom_b0", 13'h1123, 15'h0123);
      access(13'h1FF5, 1'b0, 8'h00, 1'b1);
      rom_at("f4_rom_b1", 13'h1123, 15'h1123);
      access(13'h1FFA, 1'b0, 8'h00, 1'b1);
      rom_at("f4_rom_b6", 13'h1123, 15'h6123);
      access(13'h1FFC, 1'b0, 8'h00, 1'b1);
      check("f4_1ffc_ignored", {29'd0, bank_o}, 32'd6);
      load_i = 1'b1; step(); load_i = 1'b0;
      check("f4_load_default", {29'd0, bank_o}, 32'd7);

      // ---- E0 ----
      mode_i = 3'd4; step();
      check("e0_default", {29'd0, bank_o}, 32'd4);
      rom_at("e0_rom_def1", 13'h1400, 15'h1400);
      access(13'h1FE9, 1'b0, 8'h00, 1'b1);
      access(13'h1FF3, 1'b0, 8'h00, 1'b1);
      rom_at("e0_rom_1000", 13'h1000, 15'h1000);
      rom_at("e0_rom_1400", 13'h1400, 15'h0400);
      rom_at("e0_rom_1800", 13'h1800, 15'h0C00);
      rom_at("e0_rom_1c00", 13'h1C00, 15'h1C00);
      access(13'h1FE2, 1'b0, 8'h00, 1'b1);
      check("e0_sel0", {29'd0, bank_o}, 32'd2);
      rom_at("e0_rom_sel0", 13'h1005, 15'h0805);
      access(13'h1FF8, 1'b0, 8'h00, 1'b1);
      check("e0_1ff8_no_pulse", {31'd0, hotspot_o}, 32'd0);

      // ---- 3F ----
      mode_i = 3'd5; step();
      check("3f_default", {29'd0, bank_o}, 32'd0);
      access(13'h003F, 1'b1, 8'h03, 1'b1);
      check("3f_write_bank", {29'd0, bank_o}, 32'd3);
      check("3f_write_pulse", {31'd0, hotspot_o}, 32'd1);
      rom_at("3f_rom_1000", 13'h1000, 15'h1800);
      rom_at("3f_rom_1800", 13'h1800, 15'h3800);
      access(13'h003F, 1'b0, 8'h05, 1'b1);
      check("3f_read_bank", {29'd0, bank_o}, 32'd3);
      check("3f_read_pulse", {31'd0, hotspot_o}, 32'd0);
      access(13'h1FF8, 1'b1, 8'h06, 1'b1);
      check("3f_a12_write", {29'd0, bank_o}, 32'd3);
      access(13'h0040, 1'b1, 8'h06, 1'b1);
      check("3f_a76_write", {29'd0, bank_o}, 32'd3);
      access(13'h1FF4, 1'b0, 8'h00, 1'b1);
      check("3f_1ff4", {29'd0, bank_o}, 32'd3);

      // ---- F6, mode change, load ----
      mode_i = 3'd2; step();
      check("f6_default", {29'd0, bank_o}, 32'd3);
      access(13'h1FF6, 1'b0, 8'h00, 1'b1);
      check("f6_bank0", {29'd0, bank_o}, 32'd0);
      access(13'h1FF8, 1'b0, 8'h00, 1'b1);
      check("f6_bank2", {29'd0, bank_o}, 32'd2);
      rom_at("f6_rom_b2", 13'h1ABC, 15'h2ABC);
      access(13'h1FF6, 1'b0, 8'h00, 1'b1);
      mode_i = 3'd1;
      access(13'h1FF9, 1'b0, 8'h00, 1'b1);
      check("chg_f8_default", {29'd0, bank_o}, 32'd1);
      check("chg_no_pulse", {31'd0, hotspot_o}, 32'd0);
      load_i = 1'b1;
      access(13'h1FF8, 1'b0, 8'h00, 1'b1);
      check("load_no_pulse", {31'd0, hotspot_o}, 32'd0);
      check("load_bank", {29'd0, bank_o}, 32'd1);
      load_i = 1'b0;
      access(13'h1FF8, 1'b0, 8'h00, 1'b1);
      check("post_load_bank", {29'd0, bank_o}, 32'd0);
      check("post_load_pulse", {31'd0, hotspot_o}, 32'd1);

      // ---- mode 0 and reserved mode ----
      mode_i = 3'd0; step();
      check("m0_bank", {29'd0, bank_o}, 32'd0);
      rom_at("m0_rom", 13'h1FFF, 15'h0FFF);
      access(13'h1FF8, 1'b0, 8'h00, 1'b1);
      check("m0_no_pulse", {31'd0, hotspot_o}, 32'd0);
      mode_i = 3'd6;
      access(13'h1FF9, 1'b0, 8'h00, 1'b1);
      check("m6_bank", {29'd0, bank_o}, 32'd0);
      rom_at("m6_rom", 13'h1234, 15'h0234);

      // ---- asynchronous reset mid-operation ----
      mode_i = 3'd3; step();
      check("pre_rst_bank", {29'd0, bank_o}, 32'd7);
      adr_i = 13'h0000;
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_bank", {29'd0, bank_o}, 32'd0);
      check("async_rst_rom", {17'd0, rom_adr_o}, 32'd0);
      #2 rst_ni = 1'b1;
      step();
      check("post_rst_default", {29'd0, bank_o}, 32'd7);
      check("post_rst_pulse", {31'd0, hotspot_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
